// File: rtl/input_stream_loader_if.sv
// Loader bus: host input stream, instruction/data memory write ports and loader status.
// The checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface input_stream_loader_if #(
   parameter int IN_WIDTH   = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic [IN_WIDTH-1:0]   input_data;
   logic                  input_vld;
   logic                  input_rdy;
   logic                  instr_wen;
   logic [ADDR_WIDTH-1:0] instr_wadr;
   logic [DATA_WIDTH-1:0] instr_wdata;
   logic                  mem_wen;
   logic                  mem_wrdy;
   logic [ADDR_WIDTH-1:0] mem_wadr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [ADDR_WIDTH-1:0] output_max_adr;
   logic [ADDR_WIDTH-1:0] output_adr_offset;
   logic                  cfg_vld;
   logic                  load_done;
   logic                  core_done;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum;
`endif

   modport slave (
      input  input_data, input_vld, mem_wrdy, core_done,
      output input_rdy, instr_wen, instr_wadr, instr_wdata,
      output mem_wen, mem_wadr, mem_wdata,
      output output_max_adr, output_adr_offset, cfg_vld, load_done
`ifdef LOADER_CHECKSUM_EN
      , output checksum
`endif
   );

   modport master (
      output input_data, input_vld, mem_wrdy, core_done,
      input  input_rdy, instr_wen, instr_wadr, instr_wdata,
      input  mem_wen, mem_wadr, mem_wdata,
      input  output_max_adr, output_adr_offset, cfg_vld, load_done
`ifdef LOADER_CHECKSUM_EN
      , input checksum
`endif
   );
endinterface

// File: rtl/input_stream_loader.sv
// Front-end loader: parses config beats, then instruction and data word pairs, into memories.
// Optional running XOR checksum of all assembled words under LOADER_CHECKSUM_EN.
//
// state   | meaning
// S_CFG   | capturing config beats in fixed order
// S_INSTR | pairing beats into instruction words, one-cycle write strobe
// S_DATA  | pairing beats into data words, write held until mem_wrdy
// S_DONE  | load complete, stream blocked until core_done
module input_stream_loader #(
   parameter int IN_WIDTH    = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int NUM_CONFIGS = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   input_stream_loader_if.slave bus
);
   localparam int CW            = $clog2(NUM_CONFIGS);
   localparam int CFG_INSTR_MAX = 0;
   localparam int CFG_IN_MAX    = 1;
   localparam int CFG_IN_OFFSET = 2;
   localparam int CFG_OUT_MAX   = 3;
   localparam int CFG_OUT_OFS   = 4;

   typedef enum logic [1:0] {S_CFG, S_INSTR, S_DATA, S_DONE} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] cfg_q [NUM_CONFIGS];
   logic [CW-1:0]         cfg_cnt_q;
   logic [ADDR_WIDTH-1:0] instr_cnt_q;
   logic [ADDR_WIDTH-1:0] data_cnt_q;
   logic [IN_WIDTH-1:0]   half_q;
   logic                  hi_phase_q;
   logic                  last_q;
   logic                  cfg_vld_q;
   logic                  load_done_q;
   logic                  instr_wen_q;
   logic [ADDR_WIDTH-1:0] instr_wadr_q;
   logic [DATA_WIDTH-1:0] instr_wdata_q;
   logic                  mem_wen_q;
   logic [ADDR_WIDTH-1:0] mem_wadr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_q;
`endif

   logic                  input_rdy;
   logic                  beat_fire;
   logic                  commit;
   logic [DATA_WIDTH-1:0] word_d;

   assign input_rdy = (state_q != S_DONE) && !(mem_wen_q && !bus.mem_wrdy);
   assign beat_fire = bus.input_vld && input_rdy;
   assign commit    = mem_wen_q && bus.mem_wrdy;
   assign word_d    = {bus.input_data, half_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_CFG;
         for (int i = 0; i < NUM_CONFIGS; i++) cfg_q[i] <= '0;
         cfg_cnt_q     <= '0;
         instr_cnt_q   <= '0;
         data_cnt_q    <= '0;
         half_q        <= '0;
         hi_phase_q    <= 1'b0;
         last_q        <= 1'b0;
         cfg_vld_q     <= 1'b0;
         load_done_q   <= 1'b0;
         instr_wen_q   <= 1'b0;
         instr_wadr_q  <= '0;
         instr_wdata_q <= '0;
         mem_wen_q     <= 1'b0;
         mem_wadr_q    <= '0;
         mem_wdata_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         checksum_q    <= '0;
`endif
      end else begin
         instr_wen_q <= 1'b0;
         load_done_q <= 1'b0;
         if (commit) mem_wen_q <= 1'b0;

         unique case (state_q)
            S_CFG: begin
               if (beat_fire) begin
                  cfg_q[cfg_cnt_q] <= bus.input_data;
                  if (cfg_cnt_q == CW'(NUM_CONFIGS - 1)) begin
                     cfg_cnt_q <= '0;
                     cfg_vld_q <= 1'b1;
                     state_q   <= S_INSTR;
                  end else begin
                     cfg_cnt_q <= cfg_cnt_q + CW'(1);
                  end
               end
            end

            S_INSTR: begin
               if (beat_fire && !hi_phase_q) begin
                  half_q     <= bus.input_data;
                  hi_phase_q <= 1'b1;
               end else if (beat_fire) begin
                  hi_phase_q    <= 1'b0;
                  instr_wen_q   <= 1'b1;
                  instr_wadr_q  <= instr_cnt_q;
                  instr_wdata_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
                  checksum_q    <= checksum_q ^ word_d;
`endif
                  if (instr_cnt_q == cfg_q[CFG_INSTR_MAX]) begin
                     state_q    <= S_DATA;
                     data_cnt_q <= '0;
                  end else begin
                     instr_cnt_q <= instr_cnt_q + ADDR_WIDTH'(1);
                  end
               end
            end

            S_DATA: begin
               if (beat_fire && !hi_phase_q) begin
                  half_q     <= bus.input_data;
                  hi_phase_q <= 1'b1;
               end else if (beat_fire) begin
                  hi_phase_q  <= 1'b0;
                  mem_wen_q   <= 1'b1;
                  mem_wadr_q  <= cfg_q[CFG_IN_OFFSET] + data_cnt_q;
                  mem_wdata_q <= word_d;
                  last_q      <= (data_cnt_q == cfg_q[CFG_IN_MAX]);
                  data_cnt_q  <= data_cnt_q + ADDR_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                  checksum_q  <= checksum_q ^ word_d;
`endif
               end
               // the host sends nothing after the last word, so its commit cannot collide with a new beat
               if (commit && last_q) begin
                  last_q      <= 1'b0;
                  load_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end

            S_DONE: begin
               if (bus.core_done) begin
                  state_q     <= S_CFG;
                  cfg_vld_q   <= 1'b0;
                  cfg_cnt_q   <= '0;
                  instr_cnt_q <= '0;
                  data_cnt_q  <= '0;
                  hi_phase_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  checksum_q  <= '0;
`endif
               end
            end
         endcase
      end
   end

   assign bus.input_rdy         = input_rdy;
   assign bus.instr_wen         = instr_wen_q;
   assign bus.instr_wadr        = instr_wadr_q;
   assign bus.instr_wdata       = instr_wdata_q;
   assign bus.mem_wen           = mem_wen_q;
   assign bus.mem_wadr          = mem_wadr_q;
   assign bus.mem_wdata         = mem_wdata_q;
   assign bus.output_max_adr    = cfg_q[CFG_OUT_MAX];
   assign bus.output_adr_offset = cfg_q[CFG_OUT_OFS];
   assign bus.cfg_vld           = cfg_vld_q;
   assign bus.load_done         = load_done_q;
`ifdef LOADER_CHECKSUM_EN
   assign bus.checksum          = checksum_q;
`endif
endmodule
